// File: rtl/vec_issue_ctrl.sv
// Sequential issue stage: decodes one instruction per handshake, splits vector
// instructions into lane beats and tracks BEQ resolution with a flush window.
module vec_issue_ctrl #(
  parameter int VLEN         = 8,
  parameter int LANES        = 2,
  parameter int FLUSH_CYCLES = 2,
  localparam int IDX_W       = (VLEN > 1) ? $clog2(VLEN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instn_valid,
  input  logic [31:0]      instn,
  output logic             instn_ready,
  output logic             ctrl_valid,
  input  logic             ctrl_ready,
  output logic [5:0]       opcode,
  output logic             RegDst,
  output logic             ALUSrc,
  output logic             branch,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             VRegWrite,
  output logic [1:0]       ALUOp,
  output logic [IDX_W-1:0] elem_idx,
  output logic             vec_last,
  input  logic             PCSrc_valid,
  input  logic             PCSrc,
  output logic             beq_enable,
  output logic             flush,
  output logic             illegal
);

  localparam int BEATS = VLEN / LANES;
  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [IDX_W-1:0] LANE_STEP = IDX_W'(LANES);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(VLEN - LANES);

  localparam logic [5:0] OP_RTYPE   = 6'b000000;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_SET     = 6'b001101;
  localparam logic [5:0] OP_RVVTYPE = 6'b010000;
  localparam logic [5:0] OP_RVSTYPE = 6'b010001;
  localparam logic [5:0] OP_LW_R    = 6'b100000;
  localparam logic [5:0] OP_LW_V    = 6'b100001;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW_R    = 6'b101000;
  localparam logic [5:0] OP_SW_V    = 6'b101001;
  localparam logic [5:0] OP_SW      = 6'b101011;

  localparam logic [1:0] S_ISSUE    = 2'd0;
  localparam logic [1:0] S_VEC_SEQ  = 2'd1;
  localparam logic [1:0] S_BR_WAIT  = 2'd2;
  localparam logic [1:0] S_BR_FLUSH = 2'd3;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       branch;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       vreg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE:          begin c.reg_dst = 1'b1; c.alu_op = 2'b10; c.reg_write = 1'b1; end
      OP_RVVTYPE:        begin c.reg_dst = 1'b1; c.alu_op = 2'b10; c.vreg_write = 1'b1; end
      OP_RVSTYPE:        begin c.reg_dst = 1'b1; c.alu_op = 2'b11; c.vreg_write = 1'b1; end
      OP_LW:             begin c.alu_op = 2'b10; c.alu_src = 1'b1; c.reg_write = 1'b1;
                               c.mem_to_reg = 1'b1; end
      OP_SW:             begin c.alu_src = 1'b1; c.mem_write = 1'b1; end
      OP_LW_R, OP_LW_V:  begin c.reg_dst = 1'b1; c.alu_op = 2'b10; c.reg_write = 1'b1;
                               c.mem_to_reg = 1'b1; end
      OP_SW_R, OP_SW_V:  begin c.reg_dst = 1'b1; c.alu_op = 2'b10; c.mem_write = 1'b1; end
      OP_BEQ:            begin c.alu_op = 2'b01; c.branch = 1'b1; end
      OP_ADDI, OP_SET:   begin c.alu_src = 1'b1; c.reg_write = 1'b1; end
      default:           c = '0;
    endcase
    return c;
  endfunction

  function automatic logic op_defined(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_BEQ, OP_ADDI, OP_SET, OP_RVVTYPE, OP_RVSTYPE,
      OP_LW_R, OP_LW_V, OP_LW, OP_SW_R, OP_SW_V, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic op_vector(input logic [5:0] op);
    return (op == OP_RVVTYPE) || (op == OP_RVSTYPE) || (op == OP_LW_V) || (op == OP_SW_V);
  endfunction

  logic [1:0]       state_q, state_d;
  logic             ctrl_valid_q, ctrl_valid_d;
  logic [5:0]       opcode_q, opcode_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [IDX_W-1:0] elem_idx_q, elem_idx_d;
  logic             vec_last_q, vec_last_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             illegal_q, illegal_d;

  logic             out_free;
  logic             accept;
  logic [5:0]       instn_op;
  logic [IDX_W-1:0] elem_next;
  logic             unused_instn;

  assign instn_op     = instn[31:26];
  assign unused_instn = ^instn[25:0];
  assign out_free     = !ctrl_valid_q || ctrl_ready;
  assign instn_ready  = rst_n && (state_q == S_ISSUE) && out_free;
  assign accept       = instn_valid && instn_ready;
  assign elem_next    = elem_idx_q + LANE_STEP;

  always_comb begin
    state_d      = state_q;
    ctrl_valid_d = ctrl_valid_q;
    opcode_d     = opcode_q;
    ctrl_d       = ctrl_q;
    elem_idx_d   = elem_idx_q;
    vec_last_d   = vec_last_q;
    flush_cnt_d  = flush_cnt_q;
    illegal_d    = 1'b0;
    // A consumed beat empties the register unless a new one is loaded below.
    if (out_free) ctrl_valid_d = 1'b0;
    case (state_q)
      S_ISSUE: begin
        if (accept) begin
          if (!op_defined(instn_op)) begin
            illegal_d = 1'b1;
          end else begin
            ctrl_valid_d = 1'b1;
            opcode_d     = instn_op;
            ctrl_d       = decode_ctrl(instn_op);
            elem_idx_d   = '0;
            vec_last_d   = 1'b1;
            if (op_vector(instn_op) && (BEATS > 1)) begin
              vec_last_d = 1'b0;
              state_d    = S_VEC_SEQ;
            end else if (instn_op == OP_BEQ) begin
              state_d = S_BR_WAIT;
            end
          end
        end
      end
      S_VEC_SEQ: begin
        // Opcode and decode stay latched; only the element window advances.
        if (out_free) begin
          ctrl_valid_d = 1'b1;
          elem_idx_d   = elem_next;
          vec_last_d   = (elem_next == LAST_IDX);
          if (elem_next == LAST_IDX) state_d = S_ISSUE;
        end
      end
      S_BR_WAIT: begin
        if (PCSrc_valid) begin
          if (PCSrc) begin
            state_d     = S_BR_FLUSH;
            flush_cnt_d = CNT_W'(FLUSH_CYCLES);
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_BR_FLUSH: begin
        flush_cnt_d = flush_cnt_q - CNT_W'(1);
        if (flush_cnt_q == CNT_W'(1)) state_d = S_ISSUE;
      end
      default: state_d = S_ISSUE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_ISSUE;
      ctrl_valid_q <= 1'b0;
      opcode_q     <= '0;
      ctrl_q       <= '0;
      elem_idx_q   <= '0;
      vec_last_q   <= 1'b0;
      flush_cnt_q  <= '0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctrl_valid_q <= ctrl_valid_d;
      opcode_q     <= opcode_d;
      ctrl_q       <= ctrl_d;
      elem_idx_q   <= elem_idx_d;
      vec_last_q   <= vec_last_d;
      flush_cnt_q  <= flush_cnt_d;
      illegal_q    <= illegal_d;
    end
  end

  assign ctrl_valid = ctrl_valid_q;
  assign opcode     = opcode_q;
  assign RegDst     = ctrl_q.reg_dst;
  assign ALUSrc     = ctrl_q.alu_src;
  assign branch     = ctrl_q.branch;
  assign MemWrite   = ctrl_q.mem_write;
  assign RegWrite   = ctrl_q.reg_write;
  assign MemtoReg   = ctrl_q.mem_to_reg;
  assign VRegWrite  = ctrl_q.vreg_write;
  assign ALUOp      = ctrl_q.alu_op;
  assign elem_idx   = elem_idx_q;
  assign vec_last   = vec_last_q;
  assign beq_enable = (state_q == S_BR_WAIT) || (state_q == S_BR_FLUSH);
  assign flush      = (state_q == S_BR_FLUSH);
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Bench for vec_issue_ctrl: directed scenarios plus a randomized run against a
// transaction-level model (beat queue, outstanding-work counters).
module tb_vec_issue_ctrl;

  localparam int VLEN  = 8;
  localparam int LANES = 2;
  localparam int FC    = 2;
  localparam int BEATS = VLEN / LANES;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SET  = 6'b001101;
  localparam logic [5:0] OP_RVV  = 6'b010000;
  localparam logic [5:0] OP_RVS  = 6'b010001;
  localparam logic [5:0] OP_LW_R = 6'b100000;
  localparam logic [5:0] OP_LW_V = 6'b100001;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW_R = 6'b101000;
  localparam logic [5:0] OP_SW_V = 6'b101001;
  localparam logic [5:0] OP_SW   = 6'b101011;

  typedef struct packed {
    logic [5:0] op;
    logic [8:0] dec;
    logic [2:0] idx;
    logic       last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instn_valid = 1'b0;
  logic [31:0] instn = '0;
  logic        instn_ready;
  logic        ctrl_valid;
  logic        ctrl_ready = 1'b0;
  logic [5:0]  opcode;
  logic        RegDst, ALUSrc, branch, MemWrite, RegWrite, MemtoReg, VRegWrite;
  logic [1:0]  ALUOp;
  logic [2:0]  elem_idx;
  logic        vec_last;
  logic        PCSrc_valid = 1'b0;
  logic        PCSrc = 1'b0;
  logic        beq_enable, flush, illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vec_issue_ctrl #(.VLEN(VLEN), .LANES(LANES), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .instn_valid(instn_valid), .instn(instn),
    .instn_ready(instn_ready), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
    .opcode(opcode), .RegDst(RegDst), .ALUSrc(ALUSrc), .branch(branch),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .VRegWrite(VRegWrite), .ALUOp(ALUOp), .elem_idx(elem_idx), .vec_last(vec_last),
    .PCSrc_valid(PCSrc_valid), .PCSrc(PCSrc), .beq_enable(beq_enable),
    .flush(flush), .illegal(illegal)
  );

  // {RegDst,ALUSrc,branch,MemWrite,RegWrite,MemtoReg,VRegWrite,ALUOp}
  function automatic logic [8:0] exp_dec(input logic [5:0] op);
    case (op)
      OP_R:             return 9'b1_0_0_0_1_0_0_10;
      OP_RVV:           return 9'b1_0_0_0_0_0_1_10;
      OP_RVS:           return 9'b1_0_0_0_0_0_1_11;
      OP_LW:            return 9'b0_1_0_0_1_1_0_10;
      OP_SW:            return 9'b0_1_0_1_0_0_0_00;
      OP_LW_R, OP_LW_V: return 9'b1_0_0_0_1_1_0_10;
      OP_SW_R, OP_SW_V: return 9'b1_0_0_1_0_0_0_10;
      OP_BEQ:           return 9'b0_0_1_0_0_0_0_01;
      OP_ADDI, OP_SET:  return 9'b0_1_0_0_1_0_0_00;
      default:          return 9'b0;
    endcase
  endfunction

  function automatic logic is_vec(input logic [5:0] op);
    return op inside {OP_RVV, OP_RVS, OP_LW_V, OP_SW_V};
  endfunction

  function automatic logic is_def(input logic [5:0] op);
    return op inside {OP_R, OP_BEQ, OP_ADDI, OP_SET, OP_RVV, OP_RVS,
                      OP_LW_R, OP_LW_V, OP_LW, OP_SW_R, OP_SW_V, OP_SW};
  endfunction

  function automatic logic [5:0] rand_op();
    case ($urandom_range(0, 13))
      0: return OP_R;      1: return OP_BEQ;   2: return OP_ADDI;  3: return OP_SET;
      4: return OP_RVV;    5: return OP_RVS;   6: return OP_LW_R;  7: return OP_LW_V;
      8: return OP_LW;     9: return OP_SW_R;  10: return OP_SW_V; 11: return OP_SW;
      12: return 6'b111111;
      default: return 6'b111110;
    endcase
  endfunction

  function automatic logic [8:0] obs_dec();
    return {RegDst, ALUSrc, branch, MemWrite, RegWrite, MemtoReg, VRegWrite, ALUOp};
  endfunction

  function automatic logic [18:0] obs_beat();
    return {opcode, obs_dec(), elem_idx, vec_last};
  endfunction

  function automatic logic [23:0] obs_all();
    return {ctrl_valid, opcode, obs_dec(), elem_idx, vec_last, beq_enable, flush,
            illegal, instn_ready};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; instn_valid = 1'b0; ctrl_ready = 1'b0; PCSrc_valid = 1'b0; PCSrc = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk); #1;
    total++;
    if (obs_all() !== 24'h0) begin
      bad++; $display("FAIL reset_outputs got=%h want=000000", obs_all());
    end
    @(negedge clk); rst_n = 1'b1; #1;
    total++;
    if ({instn_ready, ctrl_valid} !== 2'b10) begin
      bad++; $display("FAIL reset_release ready/valid got=%b want=10", {instn_ready, ctrl_valid});
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [4];
    ops = '{OP_R, OP_LW, OP_SW, OP_ADDI};
    ctrl_ready = 1'b1; PCSrc_valid = 1'b0;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i < 4) begin instn_valid = 1'b1; instn = {ops[i], 26'($urandom)}; end
      else instn_valid = 1'b0;
      #1;
      total++;
      if (instn_ready !== 1'b1) begin
        bad++; $display("FAIL b2b_ready[%0d] got=%b want=1", i, instn_ready);
      end
      if (i > 0) begin
        total++;
        if ({ctrl_valid, obs_beat()} !== {1'b1, ops[i-1], exp_dec(ops[i-1]), 3'd0, 1'b1}) begin
          bad++; $display("FAIL b2b_beat[%0d] got=%h want=%h", i - 1, {ctrl_valid, obs_beat()},
                          {1'b1, ops[i-1], exp_dec(ops[i-1]), 3'd0, 1'b1});
        end
      end
    end
    @(negedge clk); #1;
    total++;
    if (ctrl_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_drain ctrl_valid got=%b want=0", ctrl_valid);
    end
  endtask

  task automatic test_vector_stall();
    logic pat [6];
    int exp_idx;
    logic exp_rdy;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    @(negedge clk);
    ctrl_ready = 1'b1; instn_valid = 1'b1; instn = {OP_RVV, 26'($urandom)};
    #1;
    total++;
    if (instn_ready !== 1'b1) begin
      bad++; $display("FAIL vec_accept_ready got=%b want=1", instn_ready);
    end
    exp_idx = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      instn_valid = 1'b0; ctrl_ready = pat[k];
      #1;
      total++;
      if ({ctrl_valid, obs_beat()} !== {1'b1, OP_RVV, exp_dec(OP_RVV), 3'(exp_idx), exp_idx == VLEN - LANES}) begin
        bad++; $display("FAIL vec_beat[%0d] got=%h want=%h", k, {ctrl_valid, obs_beat()},
                        {1'b1, OP_RVV, exp_dec(OP_RVV), 3'(exp_idx), exp_idx == VLEN - LANES});
      end
      exp_rdy = (exp_idx == VLEN - LANES) ? pat[k] : 1'b0;
      total++;
      if (instn_ready !== exp_rdy) begin
        bad++; $display("FAIL vec_ready[%0d] got=%b want=%b", k, instn_ready, exp_rdy);
      end
      if (pat[k] && exp_idx < VLEN - LANES) exp_idx += LANES;
    end
    @(negedge clk); ctrl_ready = 1'b1; #1;
    total++;
    if (ctrl_valid !== 1'b0) begin
      bad++; $display("FAIL vec_extra_beat ctrl_valid got=%b want=0", ctrl_valid);
    end
  endtask

  task automatic test_beq_taken();
    logic exp_f [4];
    exp_f = '{1'b1, 1'b1, 1'b0, 1'b0};
    @(negedge clk);
    ctrl_ready = 1'b1; instn_valid = 1'b1; instn = {OP_BEQ, 26'($urandom)};
    #1;
    @(negedge clk); instn_valid = 1'b0; #1;
    total++;
    if ({beq_enable, flush, ctrl_valid, branch, vec_last} !== 5'b10111) begin
      bad++; $display("FAIL beq_t_wait got=%b want=10111", {beq_enable, flush, ctrl_valid, branch, vec_last});
    end
    @(negedge clk); PCSrc_valid = 1'b1; PCSrc = 1'b1; #1;
    total++;
    if ({beq_enable, flush, instn_ready} !== 3'b100) begin
      bad++; $display("FAIL beq_t_resolve got=%b want=100", {beq_enable, flush, instn_ready});
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); PCSrc_valid = 1'b0; PCSrc = 1'b0; #1;
      total++;
      if ({beq_enable, flush, instn_ready} !== {exp_f[k], exp_f[k], !exp_f[k]}) begin
        bad++; $display("FAIL beq_t_flush[%0d] got=%b want=%b", k, {beq_enable, flush, instn_ready},
                        {exp_f[k], exp_f[k], !exp_f[k]});
      end
    end
  endtask

  task automatic test_beq_not_taken_stalled();
    logic [5:0] low;
    @(negedge clk);
    ctrl_ready = 1'b1; instn_valid = 1'b1; instn = {OP_BEQ, 26'($urandom)};
    #1;
    @(negedge clk); instn_valid = 1'b0; ctrl_ready = 1'b0; PCSrc_valid = 1'b1; PCSrc = 1'b0; #1;
    total++;
    if ({beq_enable, ctrl_valid} !== 2'b11) begin
      bad++; $display("FAIL beq_nt_wait got=%b want=11", {beq_enable, ctrl_valid});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); PCSrc_valid = 1'b0; ctrl_ready = (k == 2); #1;
      total++;
      low = {beq_enable, flush, instn_ready, ctrl_valid, branch, vec_last};
      if (low !== {3'b00, (k == 2), 3'b111}) begin
        bad++; $display("FAIL beq_nt_hold[%0d] got=%b want=%b", k, low, {2'b00, (k == 2), 3'b111});
      end
      total++;
      if (obs_beat() !== {OP_BEQ, exp_dec(OP_BEQ), 3'd0, 1'b1}) begin
        bad++; $display("FAIL beq_nt_beat[%0d] got=%h want=%h", k, obs_beat(),
                        {OP_BEQ, exp_dec(OP_BEQ), 3'd0, 1'b1});
      end
    end
    @(negedge clk); #1;
    total++;
    if ({ctrl_valid, flush} !== 2'b00) begin
      bad++; $display("FAIL beq_nt_drain got=%b want=00", {ctrl_valid, flush});
    end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    ctrl_ready = 1'b1; instn_valid = 1'b1; instn = {6'b111111, 26'($urandom)};
    #1;
    total++;
    if (instn_ready !== 1'b1) begin
      bad++; $display("FAIL ill_ready got=%b want=1", instn_ready);
    end
    @(negedge clk); instn = {OP_R, 26'($urandom)}; #1;
    total++;
    if ({illegal, ctrl_valid, instn_ready} !== 3'b101) begin
      bad++; $display("FAIL ill_pulse got=%b want=101", {illegal, ctrl_valid, instn_ready});
    end
    @(negedge clk); instn_valid = 1'b0; #1;
    total++;
    if ({illegal, ctrl_valid, obs_beat()} !== {2'b01, OP_R, exp_dec(OP_R), 3'd0, 1'b1}) begin
      bad++; $display("FAIL ill_next_beat got=%h want=%h", {illegal, ctrl_valid, obs_beat()},
                      {2'b01, OP_R, exp_dec(OP_R), 3'd0, 1'b1});
    end
  endtask

  task automatic test_reset_mid_vector();
    @(negedge clk);
    ctrl_ready = 1'b1; instn_valid = 1'b1; instn = {OP_RVV, 26'($urandom)};
    #1;
    @(negedge clk); instn_valid = 1'b0; #1;
    @(negedge clk); #1;
    total++;
    if ({ctrl_valid, elem_idx} !== {1'b1, 3'd2}) begin
      bad++; $display("FAIL rstv_beat1 got=%b want=1010", {ctrl_valid, elem_idx});
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (obs_all() !== 24'h0) begin
      bad++; $display("FAIL rstv_outputs got=%h want=000000", obs_all());
    end
    @(negedge clk); rst_n = 1'b1; #1;
    total++;
    if ({instn_ready, ctrl_valid} !== 2'b10) begin
      bad++; $display("FAIL rstv_release got=%b want=10", {instn_ready, ctrl_valid});
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      total++;
      if ({ctrl_valid, beq_enable, flush} !== 3'b000) begin
        bad++; $display("FAIL rstv_nobeat[%0d] got=%b want=000", k, {ctrl_valid, beq_enable, flush});
      end
    end
  endtask

  task automatic test_random();
    beat_t exp_q [$];
    beat_t b;
    int vec_left, flush_left;
    logic br_wait, ill_next, out_occ, next_occ, exp_rdy, free, acc;
    logic [5:0] op;
    vec_left = 0; flush_left = 0; br_wait = 1'b0; ill_next = 1'b0; out_occ = 1'b0;
    apply_reset();
    for (int cyc = 0; cyc < 700; cyc++) begin
      @(negedge clk);
      if (cyc < 650) begin
        instn_valid = ($urandom_range(0, 9) < 7);
        instn       = {rand_op(), 26'($urandom)};
        ctrl_ready  = ($urandom_range(0, 9) < 6);
        PCSrc_valid = ($urandom_range(0, 9) < 3);
        PCSrc       = 1'($urandom_range(0, 1));
      end else begin
        instn_valid = 1'b0; ctrl_ready = 1'b1; PCSrc_valid = 1'b1; PCSrc = 1'b0;
      end
      #1;
      free    = !out_occ || ctrl_ready;
      exp_rdy = !br_wait && (flush_left == 0) && (vec_left == 0) && free;
      total++;
      if ({ctrl_valid, instn_ready, illegal, flush, beq_enable} !==
          {out_occ, exp_rdy, ill_next, flush_left > 0, br_wait || flush_left > 0}) begin
        bad++; $display("FAIL rnd_ctrl[%0d] valid/ready/illegal/flush/beq got=%b want=%b", cyc,
                        {ctrl_valid, instn_ready, illegal, flush, beq_enable},
                        {out_occ, exp_rdy, ill_next, flush_left > 0, br_wait || flush_left > 0});
      end
      if (out_occ && exp_q.size() > 0) begin
        total++;
        if (obs_beat() !== exp_q[0]) begin
          bad++; $display("FAIL rnd_beat[%0d] got=%h want=%h", cyc, obs_beat(), exp_q[0]);
        end
      end
      acc      = instn_valid && exp_rdy;
      op       = instn[31:26];
      next_occ = out_occ && !ctrl_ready;
      if (out_occ && ctrl_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      ill_next = acc && !is_def(op);
      if (vec_left > 0 && free) begin next_occ = 1'b1; vec_left--; end
      if (flush_left > 0) flush_left--;
      else if (br_wait && PCSrc_valid) begin
        br_wait = 1'b0;
        if (PCSrc) flush_left = FC;
      end
      if (acc && is_def(op)) begin
        next_occ = 1'b1;
        if (is_vec(op)) begin
          for (int k = 0; k < BEATS; k++) begin
            b = '{op: op, dec: exp_dec(op), idx: 3'(k * LANES), last: (k == BEATS - 1)};
            exp_q.push_back(b);
          end
          vec_left = BEATS - 1;
        end else begin
          b = '{op: op, dec: exp_dec(op), idx: 3'd0, last: 1'b1};
          exp_q.push_back(b);
          if (op == OP_BEQ) br_wait = 1'b1;
        end
      end
      out_occ = next_occ;
    end
    total++;
    if (exp_q.size() != 0 || out_occ) begin
      bad++; $display("FAIL rnd_leftover beats got=%0d want=0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_vector_stall();
    test_beq_taken();
    test_beq_not_taken_stalled();
    test_illegal();
    test_reset_mid_vector();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vec_issue_ctrl.md
# vec_issue_ctrl

Parametrised, sequential successor to the combinational main decoder with its BEQ state machine. Accepts one 32-bit instruction per valid/ready handshake and emits registered control beats toward the execute stage over a valid/ready handshake. Vector instructions are split into VLEN/LANES beats with an element index. BEQ resolution is tracked, and on a taken branch a configurable flush window is produced.

## Interface
- VLEN, 8: elements per vector register; power of two, ≥ LANES.
- LANES, 2: elements processed per beat; power of two. BEATS = VLEN/LANES.
- FLUSH_CYCLES, 2: flush pulse length after a taken branch; ≥ 1.
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instn_valid  in  1  instn is presented.
- instn  in  32  instruction; opcode = instn[31:26], encoded per the shared opcode defines.
- instn_ready  out  1  block accepts instn this cycle.
- ctrl_valid  out  1  control beat present on the outputs below.
- ctrl_ready  in  1  downstream takes the beat.
- opcode  out  6  registered opcode of the beat.
- RegDst, ALUSrc, branch, MemWrite, RegWrite, MemtoReg, VRegWrite  out  1 each  registered decode.
- ALUOp  out  2  registered decode.
- elem_idx  out  max(1,log2 VLEN)  first element of the beat; 0 for scalar beats.
- vec_last  out  1  final beat of an instruction; 1 on every scalar beat.
- PCSrc_valid  in  1  branch outcome present.
- PCSrc  in  1  1 means branch taken.
- beq_enable  out  1  a BEQ is awaiting resolution.
- flush  out  1  squash younger fetched instructions.
- illegal  out  1  one-cycle pulse when an undefined opcode is consumed.

## Operation
- States: ISSUE, VEC_SEQ, BR_WAIT, BR_FLUSH. The reset state is ISSUE.
- Output register is free when ctrl_valid=0 or ctrl_ready=1.
- instn_ready = (state==ISSUE) && output register free.
- Accept means instn_valid && instn_ready at a clock edge.
- Decode table:
  - Rtype: RegDst=1, ALUOp=10, RegWrite=1.
  - RVVtype: RegDst=1, ALUOp=10, VRegWrite=1.
  - RVStype: RegDst=1, ALUOp=11, VRegWrite=1.
  - LW: ALUOp=10, ALUSrc=1, RegWrite=1, MemtoReg=1.
  - SW: ALUOp=00, ALUSrc=1, MemWrite=1.
  - LW_R, LW_V: RegDst=1, ALUOp=10, RegWrite=1, MemtoReg=1.
  - SW_R, SW_V: RegDst=1, ALUOp=10, MemWrite=1.
  - BEQ: ALUOp=01, branch=1.
  - ADDI, SET: ALUOp=00, ALUSrc=1, RegWrite=1.
  - Every field not listed is 0.
- Scalar accept (any defined opcode except the vector and BEQ groups below): load one beat with elem_idx=0 and vec_last=1; stay in ISSUE.
- Vector accept (RVVtype, RVStype, LW_V, SW_V):
  - Load beat 0 with elem_idx=0. If BEATS>1, go to VEC_SEQ with the decoded instruction latched.
  - In VEC_SEQ, each time the output register is free, load the next beat with elem_idx += LANES.
  - The beat with elem_idx = VLEN-LANES has vec_last=1; after loading it, return to ISSUE.
  - If BEATS==1, the instruction behaves as scalar.
- BEQ accept: load one beat (branch=1, vec_last=1) and go to BR_WAIT.
- BR_WAIT:
  - beq_enable=1.
  - On PCSrc_valid with PCSrc=0, go to ISSUE.
  - On PCSrc_valid with PCSrc=1, go to BR_FLUSH with the flush counter loaded to FLUSH_CYCLES.
  - Resolution is independent of whether the BEQ beat has been taken downstream.
- BR_FLUSH:
  - flush=1 and beq_enable=1 every cycle; the counter decrements.
  - Return to ISSUE after exactly FLUSH_CYCLES cycles.
  - flush does not alter a pending ctrl beat.
- Undefined opcode: consumed (instn_ready honoured), no beat produced, illegal=1 for the next cycle, state unchanged.
- PCSrc_valid outside BR_WAIT is ignored.
- While ctrl_valid=1 and ctrl_ready=0, all beat outputs hold stable.

## Timing
- Reset (asynchronous assert, synchronous release at the clock edge):
  - state=ISSUE, counters=0.
  - ctrl_valid, all decode fields, opcode, elem_idx, vec_last, beq_enable, flush, illegal = 0.
  - instn_ready=1 once rst_n is high.
  - Reset mid-vector or mid-flush aborts the operation with no further beats.
- Latency: an instruction accepted at edge N produces ctrl_valid=1 after edge N; the following vector beats appear on consecutive cycles while ctrl_ready=1.
- Throughput: one scalar instruction per cycle with ctrl_ready held 1. A vector instruction occupies BEATS cycles.
- BEQ taken with PCSrc_valid at edge M: flush=1 for cycles M+1 through M+FLUSH_CYCLES; instn_ready rises at cycle M+FLUSH_CYCLES+1.
- A beat can be consumed and the next loaded on the same edge; there are no bubbles.

## Test plan
- Reset mid-VEC_SEQ (VLEN=8, LANES=2, after beat 1) → all outputs 0 immediately, instn_ready=1 after release, no further beats.
- Back-to-back Rtype, LW, SW, ADDI with ctrl_ready=1 → four consecutive beats matching the decode table, vec_last=1, instn_ready constantly 1.
- RVVtype, VLEN=8, LANES=2, ctrl_ready toggling 1,0,1,1,0,1 → beats with elem_idx 0,2,4,6; each stalled beat held unchanged; vec_last only on 6; instn_ready=0 until the last beat loads.
- BEQ, then PCSrc_valid=1 with PCSrc=1 two cycles later, FLUSH_CYCLES=2 → beq_enable high from the cycle after accept through the flush; flush=1 for exactly 2 cycles; instn_ready=1 on the next cycle.
- BEQ not taken with PCSrc_valid arriving while the BEQ beat is stalled (ctrl_ready=0) → returns to ISSUE, flush stays 0, beat still delivered intact.
- Undefined opcode 6'b111111 → no ctrl_valid, illegal pulses for 1 cycle, next Rtype accepted on the following cycle.
